// File: rtl/fetch_defs_pkg.sv
// Shared fetch definitions: FSM state encoding and parameter defaults.
// Imported by instr_fetch and by the control unit so both agree on the
// state encoding and the reset/timeout defaults.
package fetch_defs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_LOAD = 2'd3
  } fetch_state_e;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int          MAX_WAIT_DEFAULT = 15;

  // Wait counter must hold MAX_WAIT and is never narrower than 4 bits.
  function automatic int wait_cnt_width(input int max_wait);
    int w;
    w = $clog2(max_wait + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with load, increment and 16-bit wrap.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (pc <= RESET_PC)
//   ld, ld_val    load pc with ld_val (takes priority over inc)
//   inc           pc <= pc + 1, wrapping 16'hFFFF -> 16'h0000
//   pc            current program counter
module pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld,
  input  logic [15:0] ld_val,
  input  logic        inc,
  output logic [15:0] pc
);

  logic [15:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (ld)       pc_d = ld_val;
    else if (inc) pc_d = pc_q + 16'd1;  // natural 16-bit wrap
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE -> REQ -> (WAIT)* -> LOAD -> IDLE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fetch_en            start a fetch (sampled in IDLE only)
//   pc_ld, pc_ld_val    PC redirect; immediate in IDLE, deferred otherwise
//   mem_rdata, mem_ready  memory response
//   mem_rd, mem_addr    memory read strobe and word address (= pc)
//   instr_data, irwr    fetched word and one-cycle IR write strobe
//   pc                  program counter
//   busy                high outside IDLE
//   fetch_err           one-cycle pulse after a fetch timeout
module instr_fetch
  import fetch_defs_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        pc_ld,
  input  logic [15:0] pc_ld_val,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic [15:0] instr_data,
  output logic        irwr,
  output logic [15:0] pc,
  output logic        busy,
  output logic        fetch_err
);

  localparam int             WCW       = wait_cnt_width(MAX_WAIT);
  // WAIT cycle k sees a count of k-1, so the last allowed cycle sees MAX_WAIT-1.
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  fetch_state_e   state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]    instr_data_q, instr_data_d;
  logic           fetch_err_q, fetch_err_d;
  logic           pend_q, pend_d;
  logic [15:0]    pend_val_q, pend_val_d;

  logic           timeout;
  logic           redir_act;
  logic           pc_ld_en;
  logic           pc_inc;
  logic [15:0]    pc_target;

  // A redirect arriving in the same cycle as LOAD/timeout still counts,
  // and the newest pc_ld_val wins over an older pending one.
  always_comb begin
    timeout   = (state_q == ST_WAIT) && !mem_ready && (wait_cnt_q == WAIT_LAST);
    redir_act = pend_q || pc_ld;
    pc_target = pc_ld ? pc_ld_val : pend_val_q;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every flop uses non-blocking assignment so all registers update
    // from the same pre-edge values regardless of statement order.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first keeps this combinational; a missing
    // branch would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (fetch_en && !pc_ld) state_d = ST_REQ;
      ST_REQ:  state_d = mem_ready ? ST_LOAD : ST_WAIT;
      ST_WAIT: begin
        if (mem_ready)    state_d = ST_LOAD;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    mem_rd = (state_q == ST_REQ) || (state_q == ST_WAIT);
    busy   = (state_q != ST_IDLE);
    irwr   = (state_q == ST_LOAD) && !redir_act;  // squashed by a redirect
  end

  // Datapath next values.
  always_comb begin
    wait_cnt_d   = '0;
    instr_data_d = instr_data_q;
    fetch_err_d  = timeout;
    pend_d       = pend_q;
    pend_val_d   = pend_val_q;

    if ((state_q == ST_WAIT) && (state_d == ST_WAIT))
      wait_cnt_d = wait_cnt_q + 1'b1;

    if (mem_rd && mem_ready)
      instr_data_d = mem_rdata;

    // Pending redirect is consumed by LOAD or by a timeout.
    if ((state_q == ST_LOAD) || timeout) begin
      pend_d = 1'b0;
    end else if (pc_ld && (state_q != ST_IDLE)) begin
      pend_d     = 1'b1;
      pend_val_d = pc_ld_val;
    end

    pc_ld_en = ((state_q == ST_IDLE) && pc_ld) ||
               (((state_q == ST_LOAD) || timeout) && redir_act);
    pc_inc   = (state_q == ST_LOAD) && !redir_act;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      instr_data_q <= 16'h0000;
      fetch_err_q  <= 1'b0;
      pend_q       <= 1'b0;
      pend_val_q   <= 16'h0000;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      instr_data_q <= instr_data_d;
      fetch_err_q  <= fetch_err_d;
      pend_q       <= pend_d;
      pend_val_q   <= pend_val_d;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (pc_ld_en),
    .ld_val (pc_target),
    .inc    (pc_inc),
    .pc     (pc)
  );

  assign mem_addr   = pc;
  assign instr_data = instr_data_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        pc_ld;
  logic [15:0] pc_ld_val;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] instr_data;
  logic        irwr;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .pc_ld      (pc_ld),
    .pc_ld_val  (pc_ld_val),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .instr_data (instr_data),
    .irwr       (irwr),
    .pc         (pc),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cycles;
    int n_busy;
    logic irwr_seen;

    rst_n = 1'b0; fetch_en = 1'b0; pc_ld = 1'b0; pc_ld_val = 16'h0000;
    mem_rdata = 16'h0000; mem_ready = 1'b0;
    #3;
    check("rst_pc", pc, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_irwr", irwr, 1'b0);
    check("rst_fetch_err", fetch_err, 1'b0);
    check("rst_instr", instr_data, 16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check("post_rst_no_access", mem_rd, 1'b0);

    // Zero-wait fetch: fetch_en in cycle 1, irwr in cycle 3.
    fetch_en = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick(); fetch_en = 1'b0;
    check("zw_req_rd", mem_rd, 1'b1);
    check("zw_req_addr", mem_addr, 16'h0000);
    check("zw_req_irwr", irwr, 1'b0);
    tick();
    check("zw_load_irwr", irwr, 1'b1);
    check("zw_load_instr", instr_data, 16'h1234);
    check("zw_load_rd", mem_rd, 1'b0);
    tick();
    check("zw_pc", pc, 16'h0001);
    check("zw_irwr_off", irwr, 1'b0);
    check("zw_idle_busy", busy, 1'b0);

    // Four wait cycles: mem_rd stable cycles 2..6, irwr in cycle 7.
    mem_ready = 1'b0; mem_rdata = 16'hBEEF; fetch_en = 1'b1;
    rd_cycles = 0;
    tick(); fetch_en = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      if (mem_rd === 1'b1 && mem_addr === 16'h0001 && busy === 1'b1) rd_cycles++;
      check("ws_no_irwr", irwr, 1'b0);
      if (c == 6) mem_ready = 1'b1;
      tick();
    end
    check("ws_rd_cycles", 16'(rd_cycles), 16'd5);
    check("ws_irwr", irwr, 1'b1);
    check("ws_instr", instr_data, 16'hBEEF);
    check("ws_busy", busy, 1'b1);
    mem_ready = 1'b0;
    tick();
    check("ws_pc", pc, 16'h0002);

    // Timeout: REQ plus 15 WAIT cycles, then fetch_err pulse.
    fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    n_busy = 0; irwr_seen = 1'b0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) begin
      n_busy++;
      if (irwr === 1'b1) irwr_seen = 1'b1;
      tick();
    end
    check("to_done", busy, 1'b0);
    check("to_busy_cycles", 16'(n_busy), 16'd16);
    check("to_no_irwr", irwr_seen, 1'b0);
    check("to_err", fetch_err, 1'b1);
    check("to_pc", pc, 16'h0002);
    tick();
    check("to_err_pulse", fetch_err, 1'b0);

    // Redirect during WAIT: LOAD squashed, pc takes redirect target.
    fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    tick();
    pc_ld = 1'b1; pc_ld_val = 16'h00A0;
    tick();
    pc_ld = 1'b0;
    check("rd_pc_held", pc, 16'h0002);
    mem_ready = 1'b1; mem_rdata = 16'h5555;
    tick();
    check("rd_squash", irwr, 1'b0);
    check("rd_load_busy", busy, 1'b1);
    mem_ready = 1'b0;
    tick();
    check("rd_pc", pc, 16'h00A0);
    fetch_en = 1'b1; mem_ready = 1'b1; mem_rdata = 16'h0F0F;
    tick(); fetch_en = 1'b0;
    check("rd_next_addr", mem_addr, 16'h00A0);
    tick();
    check("rd_next_irwr", irwr, 1'b1);
    tick();
    check("rd_next_pc", pc, 16'h00A1);
    mem_ready = 1'b0;

    // Load beats fetch in IDLE; then fetch at 16'hFFFF wraps pc.
    pc_ld = 1'b1; pc_ld_val = 16'hFFFF; fetch_en = 1'b1;
    tick(); pc_ld = 1'b0;
    check("pr_no_fetch", busy, 1'b0);
    check("pr_no_rd", mem_rd, 1'b0);
    check("pr_pc", pc, 16'hFFFF);
    mem_ready = 1'b1; mem_rdata = 16'hABCD;
    tick(); fetch_en = 1'b0;
    check("wr_addr", mem_addr, 16'hFFFF);
    tick();
    check("wr_irwr", irwr, 1'b1);
    tick();
    check("wr_pc", pc, 16'h0000);
    mem_ready = 1'b0;

    // Timeout with redirect pending: redirect applied on abort.
    fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    tick();
    pc_ld = 1'b1; pc_ld_val = 16'h0123;
    tick(); pc_ld = 1'b0;
    for (int c = 0; c < 40 && busy === 1'b1; c++) tick();
    check("tr_done", busy, 1'b0);
    check("tr_err", fetch_err, 1'b1);
    check("tr_pc", pc, 16'h0123);

    // Reset in the middle of a WAIT.
    fetch_en = 1'b1;
    tick(); fetch_en = 1'b0;
    tick(); tick();
    check("mr_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 1'b0);
    check("mr_rd", mem_rd, 1'b0);
    check("mr_irwr", irwr, 1'b0);
    check("mr_err", fetch_err, 1'b0);
    check("mr_pc", pc, 16'h0000);
    check("mr_addr", mem_addr, 16'h0000);
    check("mr_instr", instr_data, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("mr_post_rd", mem_rd, 1'b0);
    check("mr_post_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
